sine_sweep_ctrl: RTL and testbench
==================================

Name: sine_sweep_ctrl

Overview:
Frequency-sweep sequencer for a pair of phase-accumulator sine generators.
- Drives delta_a, delta_b of the dual-sine subtractor datapath.
- Steps delta_a from a programmed start to a programmed stop in fixed increments.
- Holds each value for a programmable dwell; delta_b tracks delta_a plus a fixed offset to give a constant beat frequency.
- Start/busy/done handshake to the host sequencer.

Parameters:
DW, 12, delta/phase-increment width (matches sine generator delta input)
CW, 16, dwell counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active low
start  in  1  sweep request, sampled only in IDLE
abort  in  1  cancel sweep, effective in RUN
delta_start  in  DW  first delta_a value
delta_stop  in  DW  upper bound for delta_a (inclusive)
delta_step  in  DW  increment per step
dwell  in  CW  cycles each value is held (0 treated as 1)
offset  in  DW  delta_b = delta_a + offset
delta_a  out  DW  registered increment to generator A
delta_b  out  DW  registered increment to generator B
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at normal sweep completion
step_strobe  out  1  one-cycle pulse on each delta_a update after the first

Behaviour:
- Reset (rst=0, async) values: state=IDLE; delta_a=0, delta_b=0, busy=0, done=0, step_strobe=0; internal config and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge N:
  - Latch delta_start, delta_stop, delta_step, offset, dwell. Inputs are don't-care afterwards.
  - At edge N: delta_a<=delta_start, delta_b<=(delta_start+offset) mod 2^DW, cnt<=D-1 where D=max(dwell,1), busy<=1, state<=RUN.
- RUN, cnt!=0: cnt decrements; outputs hold.
- RUN, cnt==0: compute nxt=delta_a+step at DW+1 bits (no wrap).
  - If nxt>stop or step==0: state<=DONE, busy<=0, done<=1; delta_a/delta_b hold.
  - Else: delta_a<=nxt[DW-1:0], delta_b<=(nxt+offset) mod 2^DW, step_strobe<=1, cnt<=D-1.
- Each delta value is therefore presented for exactly D cycles.
- DONE: lasts one cycle (done=1), then returns to IDLE. start in DONE is ignored.
- delta_a/delta_b keep their last value in IDLE until the next start or abort.
- abort=1 in RUN (priority over step/done):
  - state<=IDLE; delta_a<=0, delta_b<=0; busy<=0.
  - No done, no step_strobe.
  - abort outside RUN has no effect.
- start while busy: ignored, no restart.
- delta_stop<delta_start: delta_start is presented for D cycles, then done.
- done and step_strobe are never high in the same cycle.
- Only delta_b wraps mod 2^DW; delta_a never wraps.
- Reset mid-sweep returns immediately to reset values.

Optional Feature:
SWEEP_BIDIR_EN
- Defined:
  - Adds state RUN_DN. When the up-sweep terminates (nxt>stop), go to RUN_DN instead of DONE; busy stays 1, the peak value is not repeated.
  - RUN_DN, cnt==0: if step==0 or delta_a<start_lat+step, go to DONE. Else delta_a-=step, delta_b updated, step_strobe=1.
  - abort applies identically in RUN_DN.
- Undefined: up-only sweep as above; RUN_DN does not exist.

Test Plan:
- Reset: assert rst=0 mid-RUN -> all outputs 0 immediately, IDLE, start accepted 1 cycle after release.
- Basic sweep: start=100, stop=130, step=10, dwell=4, offset=16.
  - delta_a = 100,110,120,130, each for 4 cycles; delta_b = 116,126,136,146.
  - 3 step_strobe pulses; busy high 16 cycles; done pulse next cycle; delta_a holds 130.
- delta_b wrap and delta_a overflow: start=0xFF0, stop=0xFFF, step=0x20, dwell=0, offset=0x010.
  - delta_b=0x000; one cycle of 0xFF0, then done (0x1010>stop); no step_strobe.
- Abort: sweep as in the basic case, abort=1 in the 6th RUN cycle -> next edge delta_a=0, delta_b=0, busy=0; done never asserted; start during busy ignored.
- Degenerate: step=0, start=50, dwell=3 -> 50 held 3 cycles then done. Separately stop=40<start=50 -> same, one value then done.
- SWEEP_BIDIR_EN: start=100, stop=120, step=10, dwell=2.
  - delta_a = 100,110,120,110,100, 2 cycles each; 4 step_strobes; busy 10 cycles; done pulse after the final 100.

Source files
------------

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: frequency-sweep sequencer driving delta_a/delta_b of a dual phase-accumulator sine pair
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start        sweep request, sampled only in IDLE
//   abort        cancel sweep, effective while sweeping
//   delta_start  first delta_a value
//   delta_stop   inclusive upper bound for delta_a
//   delta_step   increment per step
//   dwell        cycles each value is held (0 behaves as 1)
//   offset       delta_b = delta_a + offset (mod 2^DW)
//   delta_a      registered increment to generator A
//   delta_b      registered increment to generator B
//   busy         high while sweeping
//   done         one-cycle pulse at normal completion
//   step_strobe  one-cycle pulse on each delta_a update after the first
//
// Optional feature: define SWEEP_BIDIR_EN to sweep back down to the start
// value after the peak (state RUN_DN) before signalling done.
module sine_sweep_ctrl #(
  parameter int DW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] delta_start,
  input  logic [DW-1:0] delta_stop,
  input  logic [DW-1:0] delta_step,
  input  logic [CW-1:0] dwell,
  input  logic [DW-1:0] offset,
  output logic [DW-1:0] delta_a,
  output logic [DW-1:0] delta_b,
  output logic          busy,
  output logic          done,
  output logic          step_strobe
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef SWEEP_BIDIR_EN
    , RUN_DN
`endif
  } state_t;
  state_t state, state_n;
  logic [DW-1:0] start_lat, stop_lat, step_lat, off_lat;
  logic [CW-1:0] hold_lat, cnt, cnt_n, dm1;
  logic [DW-1:0] a_n, b_n;
  logic [DW:0] nxt;
  logic busy_n, ld, active, tick, abt, up_ok, dn_ok, rdn, go_up, go_dn, fin;
  logic [DW-1:0] dn;
  // Extra bit keeps the up-step comparison free of wraparound.
  assign nxt = {1'b0, delta_a} + {1'b0, step_lat};
  assign dn = delta_a - step_lat;
  assign dm1 = (dwell == '0) ? '0 : dwell - CW'(1);
  assign ld = (state == IDLE) && start;
  assign tick = (cnt == '0);
  assign up_ok = (step_lat != '0) && (nxt <= {1'b0, stop_lat});
`ifdef SWEEP_BIDIR_EN
  logic [DW:0] floor_v;
  assign floor_v = {1'b0, start_lat} + {1'b0, step_lat};
  assign rdn = (state == RUN_DN);
  // Going down is allowed only while the result stays at or above start.
  assign dn_ok = (step_lat != '0) && ({1'b0, delta_a} >= floor_v);
`else
  assign rdn = 1'b0;
  assign dn_ok = 1'b0;
`endif
  assign active = (state == RUN) || rdn;
  assign abt = active && abort;
  assign go_up = (state == RUN) && !abort && tick && up_ok;
  // The turnaround from up to down happens on the same edge, so the peak is not repeated.
  assign go_dn = active && !abort && tick && dn_ok && (rdn || !up_ok);
  assign fin = active && !abort && tick && !go_up && !go_dn;
  always_comb begin
    state_n = state;
    if (ld) state_n = RUN;
    else if (abt) state_n = IDLE;
    else if (fin) state_n = DONE;
`ifdef SWEEP_BIDIR_EN
    else if (go_dn) state_n = RUN_DN;
`endif
    else if (state == DONE) state_n = IDLE;
  end
  always_comb begin
    a_n = ld ? delta_start : abt ? '0 : go_up ? nxt[DW-1:0] : go_dn ? dn : delta_a;
    b_n = ld ? delta_start + offset : abt ? '0 : go_up ? nxt[DW-1:0] + off_lat : go_dn ? dn + off_lat : delta_b;
    cnt_n = ld ? dm1 : (go_up || go_dn) ? hold_lat : (active && !tick) ? cnt - CW'(1) : cnt;
    busy_n = ld || (busy && !abt && !fin);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      delta_a <= '0;
      delta_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      step_strobe <= 1'b0;
      cnt <= '0;
      start_lat <= '0;
      stop_lat <= '0;
      step_lat <= '0;
      off_lat <= '0;
      hold_lat <= '0;
    end else begin
      state <= state_n;
      delta_a <= a_n;
      delta_b <= b_n;
      busy <= busy_n;
      done <= fin;
      step_strobe <= go_up || go_dn;
      cnt <= cnt_n;
      if (ld) begin
        start_lat <= delta_start;
        stop_lat <= delta_stop;
        step_lat <= delta_step;
        off_lat <= offset;
        hold_lat <= dm1;
      end
    end
  end
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb_sine_sweep_ctrl: scoreboard bench for sine_sweep_ctrl with directed sweeps
module tb_sine_sweep_ctrl;
  localparam int DW = 12;
  localparam int CW = 16;
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic bsy;
    logic dn;
    logic stb;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [DW-1:0] ds = '0, dst = '0, dsp = '0, off = '0;
  logic [CW-1:0] dw = '0;
  logic [DW-1:0] delta_a, delta_b;
  logic busy, done, step_strobe;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sine_sweep_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delta_start(ds), .delta_stop(dst), .delta_step(dsp), .dwell(dw), .offset(off),
    .delta_a(delta_a), .delta_b(delta_b), .busy(busy), .done(done), .step_strobe(step_strobe)
  );
  function automatic exp_t cur();
    return {delta_a, delta_b, busy, done, step_strobe};
  endfunction
  task automatic chk(input string name, input exp_t act, input exp_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got a=%h b=%h busy=%b done=%b stb=%b, want a=%h b=%h busy=%b done=%b stb=%b",
               name, act.a, act.b, act.bsy, act.dn, act.stb, exp.a, exp.b, exp.bsy, exp.dn, exp.stb);
    end
  endtask
  task automatic push_val(input logic [DW-1:0] a, input logic [DW-1:0] b, input int n, input bit s);
    for (int i = 0; i < n; i++) q.push_back({a, b, 1'b1, 1'b0, s && i == 0});
  endtask
  task automatic push_done(input logic [DW-1:0] a, input logic [DW-1:0] b);
    q.push_back({a, b, 1'b0, 1'b1, 1'b0});
  endtask
  // Start is sampled at the next rising edge; inputs are scrambled afterwards to prove latching.
  task automatic sweep(input logic [DW-1:0] s, input logic [DW-1:0] sp, input logic [DW-1:0] stp,
                       input logic [CW-1:0] d, input logic [DW-1:0] o);
    ds = s; dst = sp; dsp = stp; dw = d; off = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ds = 12'h5A5; dst = 12'h000; dsp = 12'h001; dw = 16'd7; off = 12'h333;
  endtask
  task automatic drain(input string name, input int budget);
    int i = 0;
    while (q.size() != 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected outputs still pending, want 0", name, q.size());
      q.delete();
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (busy || done || step_strobe)) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got a=%h b=%h busy=%b done=%b stb=%b, want no activity",
                   delta_a, delta_b, busy, done, step_strobe);
        end else chk("sweep_output", cur(), q.pop_front());
      end
    end
  end
  initial begin
    #12;
    chk("reset_values", cur(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    push_val(100, 116, 4, 0);
    push_val(110, 126, 4, 1);
    push_val(120, 136, 4, 1);
    push_val(130, 146, 4, 1);
`ifdef SWEEP_BIDIR_EN
    push_val(120, 136, 4, 1);
    push_val(110, 126, 4, 1);
    push_val(100, 116, 4, 1);
    push_done(100, 116);
    sweep(100, 130, 10, 4, 16);
    drain("basic_drain", 60);
    repeat (3) @(posedge clk);
    #1 chk("basic_hold", cur(), {12'd100, 12'd116, 3'b000});
`else
    push_done(130, 146);
    sweep(100, 130, 10, 4, 16);
    drain("basic_drain", 40);
    repeat (3) @(posedge clk);
    #1 chk("basic_hold", cur(), {12'd130, 12'd146, 3'b000});
`endif
    push_val(12'hFF0, 12'h000, 1, 0);
    push_done(12'hFF0, 12'h000);
    sweep(12'hFF0, 12'hFFF, 12'h020, 0, 12'h010);
    drain("wrap_drain", 10);
    repeat (2) @(posedge clk); #1;
    push_val(100, 116, 4, 0);
    push_val(110, 126, 2, 1);
    sweep(100, 130, 10, 4, 16);
    repeat (2) @(posedge clk);
    #1 begin start = 1'b1; ds = 12'd500; end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_outputs", cur(), '0);
    repeat (6) @(posedge clk);
    #1 chk("abort_idle", cur(), '0);
    drain("abort_drain", 1);
    push_val(50, 55, 3, 0);
    push_done(50, 55);
    sweep(50, 200, 0, 3, 5);
    drain("step0_drain", 20);
    repeat (2) @(posedge clk); #1;
    push_val(50, 55, 3, 0);
    push_done(50, 55);
    sweep(50, 40, 10, 3, 5);
    drain("stop_lt_start_drain", 20);
    repeat (2) @(posedge clk); #1;
    push_val(100, 116, 3, 0);
    sweep(100, 130, 10, 4, 16);
    drain("prereset_drain", 20);
    rst = 1'b0;
    #1 chk("reset_async", cur(), '0);
    @(posedge clk);
    #1 chk("reset_held", cur(), '0);
    rst = 1'b1;
    push_val(12'hFF0, 12'h000, 1, 0);
    push_done(12'hFF0, 12'h000);
    sweep(12'hFF0, 12'hFFF, 12'h020, 0, 12'h010);
    drain("post_reset_drain", 10);
`ifdef SWEEP_BIDIR_EN
    repeat (2) @(posedge clk); #1;
    push_val(100, 105, 2, 0);
    push_val(110, 115, 2, 1);
    push_val(120, 125, 2, 1);
    push_val(110, 115, 2, 1);
    push_val(100, 105, 2, 1);
    push_done(100, 105);
    sweep(100, 120, 10, 2, 5);
    drain("bidir_drain", 30);
`endif
    repeat (5) @(posedge clk); #1;
    drain("final_drain", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
